// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage load/store controller between the EM and MW
// pipeline registers. It runs one req/ack transaction per access, steers
// store lanes, formats load data and stalls the pipeline while the bus is busy.
// Optional build macro MEM_TIMEOUT_EN adds a REQ-phase timeout that reports bus_err_m.
//
// state | meaning
// IDLE  | evaluate access from EM; aligned access launches a bus request
// REQ   | mem_req held, waiting for mem_ack (or timeout)
// DONE  | stall released; MW captures read_data_m; back to IDLE
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [1:0]  size_m,
    input  logic        sign_ext_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] read_data_m,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        bus_err_m
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  off_q, off_d;

    logic        access;
    logic        mis_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_fmt;

`ifdef MEM_TIMEOUT_EN
    logic                 bus_err_q, bus_err_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_W};
`endif

    assign access = mem_read_m | mem_write_m;

    // Alignment check and store lane steering from the live EM inputs.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = write_data_m;
        mis_in   = 1'b0;
        case (size_m)
            2'b00: begin
                be_in    = 4'b0001 << alu_result_m[1:0];
                wdata_in = {4{write_data_m[7:0]}};
            end
            2'b01: begin
                be_in    = alu_result_m[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{write_data_m[15:0]}};
                mis_in   = alu_result_m[0];
            end
            default: mis_in = |alu_result_m[1:0];
        endcase
    end

    // Load lane select and extension, using the copies latched at launch.
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (off_q)
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            2'd3:    lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_fmt = {{24{sext_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_fmt = {{16{sext_q & lane_half[15]}}, lane_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Next-state, stall and fault decode.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        size_d       = size_q;
        sext_d       = sext_q;
        off_d        = off_q;
        stall_m      = 1'b0;
        misaligned_m = 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_err_d    = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (mis_in) begin
                        misaligned_m = 1'b1;
                        rdata_d      = 32'h0;
                    end else begin
                        stall_m   = 1'b1;
                        state_d   = S_REQ;
                        mem_req_d = 1'b1;
                        mem_we_d  = mem_write_m;
                        addr_d    = {alu_result_m[31:2], 2'b00};
                        be_d      = be_in;
                        wdata_d   = wdata_in;
                        size_d    = size_m;
                        sext_d    = sign_ext_m;
                        off_d     = alu_result_m[1:0];
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                stall_m = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = load_fmt;
                    end
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = 32'h0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and bus-register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            off_q     <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= 1'b0;
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            off_q     <= off_d;
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= bus_err_d;
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign read_data_m = rdata_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err_m   = bus_err_q;
`else
    assign bus_err_m   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed accesses against a byte-level
// behavioural model, with a per-cycle compare process and literal checks.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_m, mem_write_m, sign_ext_m, mem_ack;
    logic [1:0]  size_m;
    logic [31:0] alu_result_m, write_data_m, mem_rdata;
    logic        mem_req, mem_we, stall_m, misaligned_m, bus_err_m;
    logic [31:0] mem_addr, mem_wdata, read_data_m;
    logic [3:0]  mem_be;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .size_m(size_m), .sign_ext_m(sign_ext_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .read_data_m(read_data_m),
        .stall_m(stall_m), .misaligned_m(misaligned_m), .bus_err_m(bus_err_m)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_we, exp_stall, exp_mis;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] model_rd;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, mis_seen, req_seen;
    int          stall_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int first = (a % 4) - ((a % 4) % n);
        logic [3:0] be = 4'h0;
        for (int i = 0; i < 4; i++) be[i] = (i >= first) && (i < first + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(sz);
        int first = a % 4;
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(first + k) +: 8];
        if (n < 4 && sx && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Per-cycle comparison against the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
            check("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
            check("stall_m", {31'h0, stall_m}, {31'h0, exp_stall});
            check("misaligned_m", {31'h0, misaligned_m}, {31'h0, exp_mis});
            check("bus_err_m", {31'h0, bus_err_m}, 32'h0);
            check("read_data_m", read_data_m, exp_rd);
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
                check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    task automatic idle_inputs();
        mem_read_m = 1'b0; mem_write_m = 1'b0; mem_ack = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
        exp_rd = model_rd;
    endtask

    task automatic step();
        @(negedge clk);
        stall_cnt += int'(stall_m);
        if (misaligned_m) mis_seen = 1'b1;
        if (mem_req) req_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One access from IDLE through DONE, then one idle cycle. Called at posedge+1.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rdata);
        int  n   = nbytes(sz);
        logic mis = (a % n) != 0;
        stall_cnt = 0; mis_seen = 1'b0; req_seen = 1'b0;
        mem_read_m = rd; mem_write_m = wr; size_m = sz; sign_ext_m = sx;
        alu_result_m = a; write_data_m = wd; mem_ack = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = !mis; exp_mis = mis; exp_rd = model_rd;
        step();
        if (mis) begin
            model_rd = 32'h0;
        end else begin
            for (int w = 0; w <= waits; w++) begin
                exp_req = 1'b1; exp_we = wr; exp_stall = 1'b1; exp_mis = 1'b0;
                exp_addr = a & 32'hFFFF_FFFC; exp_be = m_be(sz, a); exp_wdata = m_wdata(sz, wd);
                mem_ack = (w == waits);
                mem_rdata = (w == waits) ? rdata : 32'hDEAD_BEEF;
                @(negedge clk);
                cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
                stall_cnt += int'(stall_m);
                if (mem_req) req_seen = 1'b1;
                @(posedge clk);
                #1;
            end
            mem_ack = 1'b0;
            if (rd) model_rd = m_load(sz, sx, a, rdata);
            exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = model_rd;
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read_m = 0; mem_write_m = 0; size_m = 0; sign_ext_m = 0;
        alu_result_m = 0; write_data_m = 0; mem_ack = 0; mem_rdata = 0;
        model_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst mem_req", {31'h0, mem_req}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_be", {28'h0, mem_be}, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst read_data", read_data_m, 32'h0);
        check("rst stall", {31'h0, stall_m}, 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        chk_en = 1'b1;
        step();

        access(1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'h9999_9999);
        check("wld stall cycles", stall_cnt, 4);
        check("wld read_data", read_data_m, 32'h9999_9999);
        check("wld addr", cap_addr, 32'h100);
        check("wld be", {28'h0, cap_be}, 32'hF);

        // Reset while REQ is outstanding; a later ack must be ignored.
        chk_en = 1'b0;
        mem_read_m = 1; size_m = 2'b10; alu_result_m = 32'h40;
        @(posedge clk); #1;
        check("mid mem_req", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0; mem_read_m = 0;
        @(posedge clk); #1;
        check("mid rst mem_req", {31'h0, mem_req}, 32'h0);
        check("mid rst stall", {31'h0, stall_m}, 32'h0);
        check("mid rst read_data", read_data_m, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("late ack mem_req", {31'h0, mem_req}, 32'h0);
        check("late ack read_data", read_data_m, 32'h0);
        @(posedge clk); #1;
        check("late ack stall", {31'h0, stall_m}, 32'h0);
        model_rd = 32'h0;
        idle_inputs();
        chk_en = 1'b1;
        step();

        access(1, 0, 2'b00, 1, 32'h203, 32'h0, 0, 32'h8011_2233);
        check("sbyte be", {28'h0, cap_be}, 32'h8);
        check("sbyte read_data", read_data_m, 32'hFFFF_FF80);
        access(1, 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h8011_2233);
        check("ubyte read_data", read_data_m, 32'h0000_0080);

        access(0, 1, 2'b01, 0, 32'h2, 32'h1111_ABCD, 0, 32'h0);
        check("hst we", {31'h0, cap_we}, 32'h1);
        check("hst be", {28'h0, cap_be}, 32'hC);
        check("hst wdata", cap_wdata, 32'hABCD_ABCD);
        check("hst addr", cap_addr, 32'h0);
        check("hst read_data kept", read_data_m, 32'h0000_0080);

        access(1, 0, 2'b10, 0, 32'h6, 32'h0, 0, 32'h0);
        check("mis seen", {31'h0, mis_seen}, 32'h1);
        check("mis req never", {31'h0, req_seen}, 32'h0);
        check("mis stall", stall_cnt, 0);
        check("mis read_data", read_data_m, 32'h0);

        access(1, 0, 2'b01, 1, 32'h1002, 32'h0, 0, 32'h8001_7FFF);
        check("shalf read_data", read_data_m, 32'hFFFF_8001);
        access(1, 0, 2'b01, 0, 32'h0, 32'h0, 3, 32'h1234_ABCD);
        check("uhalf read_data", read_data_m, 32'h0000_ABCD);
        access(0, 1, 2'b00, 0, 32'h31, 32'hFFFF_FF5A, 1, 32'h0);
        check("bst be", {28'h0, cap_be}, 32'h2);
        check("bst wdata", cap_wdata, 32'h5A5A_5A5A);
        access(0, 1, 2'b10, 0, 32'h7C, 32'h0BAD_F00D, 0, 32'h0);
        check("wst wdata", cap_wdata, 32'h0BAD_F00D);
        access(0, 1, 2'b01, 0, 32'h3, 32'h1234_5678, 0, 32'h0);
        check("mis half st read_data", read_data_m, 32'h0);
        access(1, 0, 2'b11, 1, 32'h8, 32'h0, 0, 32'h8765_4321);
        check("rsvd read_data", read_data_m, 32'h8765_4321);
        access(1, 0, 2'b00, 0, 32'h1, 32'h0, 0, 32'hAABB_CCDD);
        check("byte lane1", read_data_m, 32'h0000_00CC);
`ifndef MEM_TIMEOUT_EN
        access(1, 0, 2'b10, 0, 32'h200, 32'h0, 12, 32'h0102_0304);
        check("long wait stall", stall_cnt, 14);
`endif

`ifdef MEM_TIMEOUT_EN
        chk_en = 1'b0;
        mem_read_m = 1; size_m = 2'b10; alu_result_m = 32'h44; mem_ack = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("tmo mem_req", {31'h0, mem_req}, 32'h1);
            check("tmo bus_err early", {31'h0, bus_err_m}, 32'h0);
            @(posedge clk); #1;
        end
        check("tmo mem_req drop", {31'h0, mem_req}, 32'h0);
        check("tmo bus_err", {31'h0, bus_err_m}, 32'h1);
        check("tmo read_data", read_data_m, 32'h0);
        check("tmo stall", {31'h0, stall_m}, 32'h0);
        mem_read_m = 0;
        @(posedge clk); #1;
        check("tmo bus_err clear", {31'h0, bus_err_m}, 32'h0);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
